// File: rtl/tpu_cfu_cmd_master_if.sv
// CFU command/response channel between an initiator (master) and the TPU (slave).
// Pure wiring: no state or added latency.
// Command is valid/ready; the response is valid/ready, and the master raises ready only while a command is in flight.
interface tpu_cfu_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_outputs_0
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_outputs_0
  );
endinterface

// File: rtl/tpu_cfu_cmd_master.sv
// Runs one GEMM job over the CFU port: load A/B, start, poll busy, read C into the result RAM.
// Latency: one command in flight at a time; a response may arrive in the accept cycle or later.
// Payloads are held while cmd_ready is low; rsp_ready is high only while a response is owed.
module tpu_cfu_cmd_master #(
  parameter int SRC_AW   = 8,
  parameter int RES_AW   = 10,
  parameter int POLL_GAP = 4,
  parameter int POLL_MAX = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [7:0]        job_K,
  input  logic [7:0]        job_M,
  input  logic [7:0]        job_N,
  input  logic [8:0]        job_a_words,
  input  logic [8:0]        job_b_words,
  input  logic [8:0]        job_c_rows,
  input  logic [SRC_AW-1:0] job_b_base,
  output logic              src_rd_en,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [31:0]       src_rdata,
  output logic              res_wr_en,
  output logic [RES_AW-1:0] res_addr,
  output logic [31:0]       res_wdata,
  tpu_cfu_cmd_master_if.master cfu,
  output logic              done,
  output logic              err
);

  // 11 bits hold the read index 4*row+lane for up to 511 rows.
  localparam int CW = 11;
  localparam int PW = $clog2(POLL_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH_A, S_ISSUE_A, S_FETCH_B, S_ISSUE_B,
    S_START, S_GAP, S_POLL, S_READ, S_DONE
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [PW-1:0]     pcnt, pcnt_n;
  logic              err_q, err_n;
  logic              pend, pend_n;
  logic              rd_q;
  logic [31:0]       word_q;
  logic [31:0]       wdata;
  logic [7:0]        k_q, m_q, n_q;
  logic [8:0]        a_words_q, b_words_q, c_rows_q;
  logic [SRC_AW-1:0] b_base_q;
  logic              issue, cmd_fire, rsp_fire, job_acc;
  logic [6:0]        funct;
  logic [31:0]       pl0, pl1;

  assign job_ready = (state == S_IDLE);
  assign job_acc   = job_valid && job_ready;
  assign issue     = state inside {S_ISSUE_A, S_ISSUE_B, S_START, S_POLL, S_READ};

  assign cfu.cmd_valid = issue && !pend;
  assign cmd_fire      = cfu.cmd_valid && cfu.cmd_ready;
  // A command accepted this cycle is already owed a response, so ready covers the accept cycle too.
  assign cfu.rsp_ready = pend || cmd_fire;
  assign rsp_fire      = cfu.rsp_valid && cfu.rsp_ready;
  assign pend_n        = (pend || cmd_fire) && !rsp_fire;

  // Source data is valid only in the cycle after the read; hold it so the write payload stays stable.
  assign wdata = rd_q ? src_rdata : word_q;

  assign src_rd_en = (state == S_FETCH_A) || (state == S_FETCH_B);
  assign src_addr  = (state == S_FETCH_A) ? SRC_AW'(cnt) :
                     (state == S_FETCH_B) ? SRC_AW'(b_base_q + SRC_AW'(cnt)) : '0;

  assign res_wr_en = (state == S_READ) && rsp_fire;
  assign res_addr  = res_wr_en ? RES_AW'(cnt) : '0;
  assign res_wdata = res_wr_en ? cfu.rsp_payload_outputs_0 : '0;

  assign done = (state == S_DONE);
  assign err  = err_q;

  assign cfu.cmd_payload_function_id = cfu.cmd_valid ? {funct, 3'b000} : '0;
  assign cfu.cmd_payload_inputs_0    = cfu.cmd_valid ? pl0 : '0;
  assign cfu.cmd_payload_inputs_1    = cfu.cmd_valid ? pl1 : '0;

  // State, counters, outstanding flag and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      pcnt  <= '0;
      err_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pcnt  <= pcnt_n;
      err_q <= err_n;
      pend  <= pend_n;
    end
  end

  // Job fields are captured on accept and held for the whole job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0; m_q <= '0; n_q <= '0;
      a_words_q <= '0; b_words_q <= '0; c_rows_q <= '0;
      b_base_q <= '0;
    end else if (job_acc) begin
      k_q <= job_K; m_q <= job_M; n_q <= job_N;
      a_words_q <= job_a_words; b_words_q <= job_b_words; c_rows_q <= job_c_rows;
      b_base_q <= job_b_base;
    end
  end

  // Capture the source word returned one cycle after each fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= 1'b0;
      word_q <= '0;
    end else begin
      rd_q <= src_rd_en;
      if (rd_q) word_q <= src_rdata;
    end
  end

  // Command encoding for the current state.
  always_comb begin
    funct = 7'd0;
    pl0   = '0;
    pl1   = '0;
    case (state)
      S_ISSUE_A: begin funct = 7'd0; pl0 = {5'd0, cnt, 16'h0}; pl1 = wdata; end
      S_ISSUE_B: begin funct = 7'd1; pl0 = {5'd0, cnt, 16'h0}; pl1 = wdata; end
      S_START:   begin funct = 7'd2; pl0 = {k_q, m_q, n_q, 8'h00}; end
      S_POLL:    begin funct = 7'd4; end
      S_READ:    begin funct = 7'd3; pl0 = {7'd0, cnt[10:2], 14'd0, cnt[1:0]}; end
      default:   ;
    endcase
  end

  // Next-state: phases advance on response handshakes; empty phases are skipped.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pcnt_n  = pcnt;
    err_n   = err_q;
    case (state)
      S_IDLE: if (job_acc) begin
        err_n  = 1'b0;
        cnt_n  = '0;
        pcnt_n = '0;
        if (job_a_words != 9'd0)      state_n = S_FETCH_A;
        else if (job_b_words != 9'd0) state_n = S_FETCH_B;
        else                          state_n = S_START;
      end
      S_FETCH_A: state_n = S_ISSUE_A;
      S_ISSUE_A: if (rsp_fire) begin
        if (cnt + CW'(1) == CW'(a_words_q)) begin
          cnt_n   = '0;
          state_n = (b_words_q != 9'd0) ? S_FETCH_B : S_START;
        end else begin
          cnt_n   = cnt + CW'(1);
          state_n = S_FETCH_A;
        end
      end
      S_FETCH_B: state_n = S_ISSUE_B;
      S_ISSUE_B: if (rsp_fire) begin
        if (cnt + CW'(1) == CW'(b_words_q)) begin
          cnt_n   = '0;
          state_n = S_START;
        end else begin
          cnt_n   = cnt + CW'(1);
          state_n = S_FETCH_B;
        end
      end
      // The busy bit returned by start is stale and deliberately not looked at.
      S_START: if (rsp_fire) begin
        cnt_n   = '0;
        state_n = (POLL_GAP == 0) ? S_POLL : S_GAP;
      end
      S_GAP: begin
        if (cnt == CW'(POLL_GAP - 1)) begin
          cnt_n   = '0;
          state_n = S_POLL;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_POLL: if (rsp_fire) begin
        if (cfu.rsp_payload_outputs_0[0]) begin
          if (pcnt == PW'(POLL_MAX - 1)) begin
            err_n   = 1'b1;
            state_n = S_DONE;
          end else begin
            pcnt_n = pcnt + PW'(1);
          end
        end else begin
          cnt_n   = '0;
          state_n = (c_rows_q != 9'd0) ? S_READ : S_DONE;
        end
      end
      S_READ: if (rsp_fire) begin
        if (cnt[10:2] == c_rows_q - 9'd1 && cnt[1:0] == 2'd3) state_n = S_DONE;
        else cnt_n = cnt + CW'(1);
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tpu_cfu_cmd_master.sv
// Directed bench: CFU stub with a 4x4 int8 GEMM model, source/result RAMs, command log checks.
// Poll limit is set to 11 so one setting covers both the 10-busy-then-idle and the always-busy cases.
// Stub can stall write commands for 5 cycles each and delays read-C responses by 2 cycles.
module tb_tpu_cfu_cmd_master;
  localparam int PMAX = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [7:0]  job_K = '0, job_M = '0, job_N = '0;
  logic [8:0]  job_a_words = '0, job_b_words = '0, job_c_rows = '0;
  logic [7:0]  job_b_base = '0;
  logic        src_rd_en;
  logic [7:0]  src_addr;
  logic [31:0] src_rdata = '0;
  logic        res_wr_en;
  logic [9:0]  res_addr;
  logic [31:0] res_wdata;
  logic        done, err;

  always #5 clk = ~clk;

  tpu_cfu_cmd_master_if cfu ();

  tpu_cfu_cmd_master #(.SRC_AW(8), .RES_AW(10), .POLL_GAP(4), .POLL_MAX(PMAX)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_K(job_K), .job_M(job_M), .job_N(job_N),
    .job_a_words(job_a_words), .job_b_words(job_b_words), .job_c_rows(job_c_rows),
    .job_b_base(job_b_base), .src_rd_en(src_rd_en), .src_addr(src_addr),
    .src_rdata(src_rdata), .res_wr_en(res_wr_en), .res_addr(res_addr),
    .res_wdata(res_wdata), .cfu(cfu), .done(done), .err(err)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dot(input logic [31:0] a, input logic [31:0] b);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++)
      s += int'($signed(a[k*8 +: 8])) * int'($signed(b[k*8 +: 8]));
    return s;
  endfunction

  // ---------------- source RAM ----------------
  logic [31:0] src_mem [256];
  always @(posedge clk) if (src_rd_en) src_rdata <= src_mem[src_addr];

  // ---------------- CFU stub ----------------
  logic        stall_en = 1'b0, always_busy = 1'b0;
  int          busy_cfg = 0, busy_left = 0, scnt = 0;
  logic        d1 = 1'b0, d2 = 1'b0;
  logic [31:0] d1dat = '0, d2dat = '0;
  logic [31:0] abuf [256];
  logic [31:0] bbuf [256];
  logic [31:0] cmem [64];
  logic [6:0]  f7;
  logic        fire;

  assign f7            = cfu.cmd_payload_function_id[9:3];
  assign fire          = cfu.cmd_valid && cfu.cmd_ready;
  assign cfu.cmd_ready = !(stall_en && cfu.cmd_valid && f7 <= 7'd1 && scnt < 5);
  assign cfu.rsp_valid = (fire && f7 != 7'd3) || d2;
  assign cfu.rsp_payload_outputs_0 = d2 ? d2dat :
         (fire && f7 == 7'd4) ? {31'd0, always_busy || busy_left != 0} : 32'd0;

  always @(posedge clk) begin
    d2    <= d1;
    d2dat <= d1dat;
    d1    <= 1'b0;
    if (cfu.cmd_valid && !cfu.cmd_ready) scnt <= scnt + 1;
    else scnt <= 0;
    if (fire) begin
      case (f7)
        7'd0: abuf[cfu.cmd_payload_inputs_0[23:16]] <= cfu.cmd_payload_inputs_1;
        7'd1: bbuf[cfu.cmd_payload_inputs_0[23:16]] <= cfu.cmd_payload_inputs_1;
        7'd2: begin
          busy_left <= busy_cfg;
          for (int r = 0; r < 4; r++)
            for (int l = 0; l < 4; l++)
              cmem[r*4+l] <= dot(abuf[r], bbuf[l]);
        end
        7'd3: begin
          d1    <= 1'b1;
          d1dat <= cmem[{cfu.cmd_payload_inputs_0[19:16], cfu.cmd_payload_inputs_0[1:0]}];
        end
        7'd4: if (busy_left > 0) busy_left <= busy_left - 1;
        default: ;
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic [6:0]  log_f [$];
  logic [31:0] log_a [$];
  logic [31:0] res_mem [1024];
  int          n_src = 0, n_res = 0, n_done = 0, unstable = 0, cyc = 0, t_start = 0, gap = 0;
  bit          gap_seen = 0, prev_stall = 0;
  logic [73:0] prev_pl = '0;

  always @(negedge clk) begin
    cyc++;
    if (prev_stall && (!cfu.cmd_valid ||
        {cfu.cmd_payload_function_id, cfu.cmd_payload_inputs_0, cfu.cmd_payload_inputs_1} != prev_pl))
      unstable++;
    prev_stall = cfu.cmd_valid && !cfu.cmd_ready;
    prev_pl    = {cfu.cmd_payload_function_id, cfu.cmd_payload_inputs_0, cfu.cmd_payload_inputs_1};
    if (cfu.cmd_valid && f7 == 7'd4 && !gap_seen) begin
      gap      = cyc - t_start;
      gap_seen = 1;
    end
    if (fire) begin
      log_f.push_back(f7);
      log_a.push_back(cfu.cmd_payload_inputs_0);
      if (f7 == 7'd2) t_start = cyc;
    end
    if (src_rd_en) n_src++;
    if (res_wr_en) begin
      res_mem[res_addr] = res_wdata;
      n_res++;
    end
    if (done) n_done++;
  end

  function automatic logic [12:0] outvec();
    return {job_ready, cfu.cmd_valid, cfu.rsp_ready, src_rd_en, res_wr_en, done, err,
            |cfu.cmd_payload_function_id, |cfu.cmd_payload_inputs_0, |cfu.cmd_payload_inputs_1,
            |src_addr, |res_addr, |res_wdata};
  endfunction

  task automatic start_job(input int a, input int b, input int c, input logic [7:0] bb,
                           input logic [7:0] dim);
    @(negedge clk); #1;
    log_f.delete(); log_a.delete();
    gap_seen = 0; n_src = 0; n_res = 0; n_done = 0; unstable = 0;
    for (int i = 0; i < 1024; i++) res_mem[i] = 32'hdeadbeef;
    for (int i = 0; i < 256; i++) src_mem[i] = $urandom;
    job_K = dim; job_M = dim; job_N = dim;
    job_a_words = 9'(a); job_b_words = 9'(b); job_c_rows = 9'(c); job_b_base = bb;
    job_valid = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
    // Garbage after accept: the job must run on the captured fields.
    job_K = 8'hff; job_M = 8'hff; job_N = 8'hff;
    job_a_words = 9'h1ff; job_b_words = 9'h1ff; job_c_rows = 9'h1ff; job_b_base = 8'h55;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (n_done == 0 && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    repeat (4) @(negedge clk);
    #1;
    chk({tag, "_done_pulses"}, n_done, 1);
  endtask

  task automatic check_log(input string tag, input int a, input int b, input int c,
                           input int np, input logic [7:0] dim);
    logic [6:0]  ef [$];
    logic [31:0] ea [$];
    int mism;
    mism = 0;
    for (int i = 0; i < a; i++) begin ef.push_back(7'd0); ea.push_back(i << 16); end
    for (int j = 0; j < b; j++) begin ef.push_back(7'd1); ea.push_back(j << 16); end
    ef.push_back(7'd2); ea.push_back({dim, dim, dim, 8'h00});
    for (int p = 0; p < np; p++) begin ef.push_back(7'd4); ea.push_back(32'd0); end
    for (int r = 0; r < c; r++)
      for (int l = 0; l < 4; l++) begin ef.push_back(7'd3); ea.push_back((r << 16) | l); end
    chk({tag, "_ncmd"}, log_f.size(), ef.size());
    for (int i = 0; i < ef.size() && i < log_f.size(); i++)
      if (log_f[i] !== ef[i] || log_a[i] !== ea[i]) mism++;
    chk({tag, "_order"}, mism, 0);
  endtask

  task automatic check_res(input string tag, input logic [7:0] bb);
    int mism;
    logic [7:0] bi;
    mism = 0;
    for (int r = 0; r < 4; r++)
      for (int l = 0; l < 4; l++) begin
        bi = bb + 8'(l);
        if (res_mem[r*4+l] !== dot(src_mem[r], src_mem[bi])) mism++;
      end
    chk({tag, "_res"}, mism, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit found;
    int nr;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", outvec(), 13'h1000);
    rst_n = 1'b1;

    // Basic 4x4x4 job, two busy polls.
    busy_cfg = 2;
    start_job(4, 4, 4, 8'd16, 8'd4);
    wait_done("basic");
    check_log("basic", 4, 4, 4, 3, 8'd4);
    check_res("basic", 8'd16);
    chk("basic_err", err, 0);
    chk("basic_src_reads", n_src, 8);
    chk("basic_res_writes", n_res, 16);

    // Writes stalled 5 cycles each; busy for PMAX-1 polls then idle.
    stall_en = 1'b1;
    busy_cfg = PMAX - 1;
    start_job(4, 4, 4, 8'd16, 8'd4);
    wait_done("stall");
    stall_en = 1'b0;
    check_log("stall", 4, 4, 4, PMAX, 8'd4);
    check_res("stall", 8'd16);
    chk("stall_unstable", unstable, 0);
    chk("stall_poll_gap", gap >= 5, 1);
    chk("stall_err", err, 0);

    // Always busy: PMAX polls, abort with err, no C reads.
    always_busy = 1'b1;
    start_job(1, 1, 2, 8'd16, 8'd4);
    wait_done("abort");
    always_busy = 1'b0;
    check_log("abort", 1, 1, 0, PMAX, 8'd4);
    chk("abort_err", err, 1);
    chk("abort_res_writes", n_res, 0);

    // Empty job: only start and one poll; next-job accept clears err.
    busy_cfg = 0;
    start_job(0, 0, 0, 8'd0, 8'd0);
    chk("zero_err_cleared", err, 0);
    wait_done("zero");
    check_log("zero", 0, 0, 0, 1, 8'd0);
    chk("zero_src_reads", n_src, 0);
    chk("zero_res_writes", n_res, 0);

    // Reset while a read-C response is in flight.
    busy_cfg = 0;
    start_job(4, 4, 4, 8'd16, 8'd4);
    found = 0;
    k = 0;
    while (!found && k < 500) begin
      @(negedge clk);
      k++;
      if (fire && f7 == 7'd3 && cfu.cmd_payload_inputs_0 == 32'h0001_0002) found = 1;
    end
    chk("rst_read_seen", found, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", outvec(), 13'h1000);
    nr = n_res;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("late_rsp_ignored", {cfu.rsp_ready, res_wr_en}, 2'b00);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_no_write", n_res - nr, 0);
    chk("rst_idle", {job_ready, cfu.cmd_valid, done}, 3'b100);

    // Fresh job after reset, B base wrapping past the top of the source RAM.
    busy_cfg = 1;
    start_job(4, 4, 4, 8'd254, 8'd4);
    wait_done("wrap");
    check_log("wrap", 4, 4, 4, 2, 8'd4);
    check_res("wrap", 8'd254);
    chk("wrap_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
